// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter: shares one single-port RAM between fetch and load/store,
// with byte-lane stores and aligned, extended loads.   Rev 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic [31:0]   if_rdata_o,
  output logic          if_ready_o,
  input  logic          dm_req_i,
  input  logic          dm_we_i,
  input  logic [1:0]    dm_size_i,
  input  logic          dm_unsigned_i,
  input  logic [AW-1:0] dm_addr_i,
  input  logic [31:0]   dm_wdata_i,
  output logic [31:0]   dm_rdata_o,
  output logic          dm_ready_o,
  output logic          dm_misalign_o,
  output logic          ram_en_o,
  output logic [3:0]    ram_we_o,
  output logic [AW-3:0] ram_addr_o,
  output logic [31:0]   ram_wdata_o,
  input  logic [31:0]   ram_rdata_i,
  output logic          stall_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state;
  logic        gnt_dm;
  logic        acc_we;
  logic        acc_uns;
  logic        acc_mis;
  logic [1:0]  acc_size;
  logic [1:0]  acc_off;
  logic [1:0]  lat_cnt;

  logic        req_mis;
  logic [3:0]  st_we;
  logic [31:0] st_data;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^if_addr_i[1:0];

  assign stall_o = (if_req_i & ~if_ready_o) | (dm_req_i & ~dm_ready_o);

  // Store lanes and misalignment are decoded straight from the held request.
  always_comb begin
    req_mis = 1'b0;
    st_we   = 4'b1111;
    st_data = dm_wdata_i;
    case (dm_size_i)
      2'b00: begin
        st_we   = 4'b0001 << dm_addr_i[1:0];
        st_data = {4{dm_wdata_i[7:0]}};
      end
      2'b01: begin
        req_mis = dm_addr_i[0];
        st_we   = 4'b0011 << {dm_addr_i[1], 1'b0};
        st_data = {2{dm_wdata_i[15:0]}};
      end
      default: req_mis = |dm_addr_i[1:0];
    endcase
  end

  function automatic logic [31:0] align_load(input logic [31:0] w, input logic [1:0] size,
                                             input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (size)
      2'b00:   r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= IDLE;
      gnt_dm        <= 1'b0;
      acc_we        <= 1'b0;
      acc_uns       <= 1'b0;
      acc_mis       <= 1'b0;
      acc_size      <= 2'b00;
      acc_off       <= 2'b00;
      lat_cnt       <= 2'd0;
      ram_en_o      <= 1'b0;
      ram_we_o      <= 4'b0000;
      ram_addr_o    <= '0;
      ram_wdata_o   <= 32'h0;
      if_rdata_o    <= 32'h0;
      if_ready_o    <= 1'b0;
      dm_rdata_o    <= 32'h0;
      dm_ready_o    <= 1'b0;
      dm_misalign_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dm_req_i) begin
            gnt_dm      <= 1'b1;
            acc_we      <= dm_we_i;
            acc_uns     <= dm_unsigned_i;
            acc_mis     <= req_mis;
            acc_size    <= dm_size_i;
            acc_off     <= dm_addr_i[1:0];
            ram_en_o    <= ~req_mis;
            ram_we_o    <= (dm_we_i && !req_mis) ? st_we : 4'b0000;
            ram_addr_o  <= dm_addr_i[AW-1:2];
            ram_wdata_o <= st_data;
            state       <= ISSUE;
          end else if (if_req_i) begin
            gnt_dm      <= 1'b0;
            acc_we      <= 1'b0;
            acc_mis     <= 1'b0;
            acc_size    <= 2'b11;
            acc_off     <= 2'b00;
            ram_en_o    <= 1'b1;
            ram_we_o    <= 4'b0000;
            ram_addr_o  <= if_addr_i[AW-1:2];
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          ram_en_o <= 1'b0;
          ram_we_o <= 4'b0000;
          if (gnt_dm && (acc_we || acc_mis)) begin
            dm_ready_o    <= 1'b1;
            dm_misalign_o <= acc_mis;
            dm_rdata_o    <= 32'h0;
            state         <= RESP;
          end else begin
            lat_cnt <= 2'(MEM_LAT - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == 2'd0) begin
            if (gnt_dm) begin
              dm_ready_o <= 1'b1;
              dm_rdata_o <= align_load(ram_rdata_i, acc_size, acc_off, acc_uns);
            end else begin
              if_ready_o <= 1'b1;
              if_rdata_o <= ram_rdata_i;
            end
            state <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        RESP: begin
          if_ready_o    <= 1'b0;
          dm_ready_o    <= 1'b0;
          dm_misalign_o <= 1'b0;
          if_rdata_o    <= 32'h0;
          dm_rdata_o    <= 32'h0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter: scoreboard bench with a byte-addressed memory model.
// Rev 1.0
// ============================================================================
module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int LAT  = 1;
  localparam int LAT4 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_n, rst_n4;

  // DUT with MEM_LAT=1
  logic          if_req, dm_req, dm_we, dm_uns;
  logic [AW-1:0] if_addr, dm_addr;
  logic [1:0]    dm_size;
  logic [31:0]   dm_wdata, if_rdata, dm_rdata, ram_wdata, ram_rdata;
  logic          if_ready, dm_ready, dm_mis, ram_en, stall;
  logic [3:0]    ram_we;
  logic [AW-3:0] ram_addr;

  mem_port_arbiter #(.AW(AW), .MEM_LAT(LAT)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ready_o(if_ready),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_size_i(dm_size), .dm_unsigned_i(dm_uns),
    .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata), .dm_rdata_o(dm_rdata),
    .dm_ready_o(dm_ready), .dm_misalign_o(dm_mis),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
    .ram_rdata_i(ram_rdata), .stall_o(stall)
  );

  // DUT with MEM_LAT=4, fetch side only
  logic          f_if_req, f_dm_req, f_dm_we, f_dm_uns;
  logic [AW-1:0] f_if_addr, f_dm_addr;
  logic [1:0]    f_dm_size;
  logic [31:0]   f_dm_wdata, f_if_rdata, f_dm_rdata, f_ram_wdata, f_ram_rdata;
  logic          f_if_ready, f_dm_ready, f_dm_mis, f_ram_en, f_stall;
  logic [3:0]    f_ram_we;
  logic [AW-3:0] f_ram_addr;

  mem_port_arbiter #(.AW(AW), .MEM_LAT(LAT4)) dut4 (
    .clk_i(clk), .rst_n_i(rst_n4),
    .if_req_i(f_if_req), .if_addr_i(f_if_addr), .if_rdata_o(f_if_rdata), .if_ready_o(f_if_ready),
    .dm_req_i(f_dm_req), .dm_we_i(f_dm_we), .dm_size_i(f_dm_size), .dm_unsigned_i(f_dm_uns),
    .dm_addr_i(f_dm_addr), .dm_wdata_i(f_dm_wdata), .dm_rdata_o(f_dm_rdata),
    .dm_ready_o(f_dm_ready), .dm_misalign_o(f_dm_mis),
    .ram_en_o(f_ram_en), .ram_we_o(f_ram_we), .ram_addr_o(f_ram_addr), .ram_wdata_o(f_ram_wdata),
    .ram_rdata_i(f_ram_rdata), .stall_o(f_stall)
  );

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  // RAM stub for the MEM_LAT=1 DUT; unread cycles return a poison word
  logic [31:0] ram1 [0:255];
  always @(posedge clk) begin
    ram_rdata <= 32'hBADB_AD00;
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) ram1[i] <= init_word(i);
    end else if (ram_en) begin
      if (ram_we != 4'b0000) begin
        for (int k = 0; k < 4; k++)
          if (ram_we[k]) ram1[ram_addr[7:0]][8*k +: 8] <= ram_wdata[8*k +: 8];
      end else begin
        ram_rdata <= ram1[ram_addr[7:0]];
      end
    end
  end

  // Read-only RAM stub with a 4-cycle pipeline for the MEM_LAT=4 DUT
  logic [31:0] p4 [0:3];
  always @(posedge clk) begin
    p4[0] <= (f_ram_en && f_ram_we == 4'b0000) ? init_word(int'(f_ram_addr[7:0])) : 32'hBADB_AD00;
    p4[1] <= p4[0];
    p4[2] <= p4[1];
    p4[3] <= p4[2];
  end
  assign f_ram_rdata = p4[3];

  // Reference model: byte-addressed little-endian memory
  logic [7:0] mb [0:1023];

  function automatic logic [31:0] rd_word(input int a);
    return {mb[a+3], mb[a+2], mb[a+1], mb[a]};
  endfunction

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct packed {
    logic [31:0] data;
    logic        mis;
    logic        chk;
  } dm_exp_t;

  dm_exp_t     dm_q [$];
  logic [31:0] if_q [$];
  dm_exp_t     mon_e;
  logic [31:0] mon_w;
  bit          mon_on = 1'b0;

  // Scoreboard monitor
  always @(negedge clk) begin
    if (mon_on && rst_n) begin
      if (dm_ready) begin
        if (dm_q.size() == 0) check("dm_unexpected_ready", 32'(dm_ready), 32'd0);
        else begin
          mon_e = dm_q.pop_front();
          check("dm_misalign", 32'(dm_mis), 32'(mon_e.mis));
          if (mon_e.chk) check("dm_rdata", dm_rdata, mon_e.data);
        end
      end
      if (if_ready) begin
        if (if_q.size() == 0) check("if_unexpected_ready", 32'(if_ready), 32'd0);
        else begin
          mon_w = if_q.pop_front();
          check("if_rdata", if_rdata, mon_w);
        end
      end
    end
  end

  // RAM access observer
  int          en_cnt = 0;
  int          last_en_cyc = -1;
  logic [3:0]  last_we;
  logic [31:0] last_wdata;
  logic [AW-3:0] last_addr;
  always @(negedge clk) begin
    if (ram_en) begin
      en_cnt++;
      last_en_cyc = cyc;
      last_we     = ram_we;
      last_wdata  = ram_wdata;
      last_addr   = ram_addr;
    end
  end

  task automatic do_dm(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output int t0, output int tr);
    dm_exp_t     e;
    int          a;
    logic [15:0] h;
    a     = int'(addr[9:0]);
    e.mis = (size == 2'b01 && addr[0]) || (size[1] && addr[1:0] != 2'b00);
    e.data = 32'h0;
    e.chk  = 1'b1;
    if (!e.mis) begin
      if (we) begin
        e.chk = 1'b0;
        case (size)
          2'b00: mb[a] = wdata[7:0];
          2'b01: begin mb[a] = wdata[7:0]; mb[a+1] = wdata[15:8]; end
          default: for (int k = 0; k < 4; k++) mb[a+k] = wdata[8*k +: 8];
        endcase
      end else begin
        case (size)
          2'b00: e.data = uns ? {24'h0, mb[a]} : {{24{mb[a][7]}}, mb[a]};
          2'b01: begin
            h = {mb[a+1], mb[a]};
            e.data = uns ? {16'h0, h} : {{16{h[15]}}, h};
          end
          default: e.data = rd_word(a);
        endcase
      end
    end
    dm_q.push_back(e);
    @(posedge clk); #1;
    dm_req = 1'b1; dm_we = we; dm_size = size; dm_uns = uns; dm_addr = addr; dm_wdata = wdata;
    t0 = cyc;
    tr = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (dm_ready) begin tr = cyc; break; end
    end
    if (tr < 0) check("dm_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    dm_req = 1'b0; dm_addr = $urandom; dm_wdata = $urandom; dm_we = 1'($urandom);
  endtask

  task automatic do_if(input logic [31:0] addr, output int t0, output int tr);
    if_q.push_back(rd_word(int'({addr[9:2], 2'b00})));
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = addr;
    t0 = cyc;
    tr = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (if_ready) begin tr = cyc; break; end
    end
    if (tr < 0) check("if_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if_req = 1'b0; if_addr = $urandom;
  endtask

  int dt0, dtr, it0, itr, cnt0, stall_bad, pulses, t0;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) {mb[4*i+3], mb[4*i+2], mb[4*i+1], mb[4*i]} = init_word(i);
    rst_n = 1'b0; rst_n4 = 1'b0;
    if_req = 0; dm_req = 0; dm_we = 0; dm_size = 0; dm_uns = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0;
    f_if_req = 0; f_if_addr = 0; f_dm_req = 0; f_dm_we = 0; f_dm_size = 0; f_dm_uns = 0;
    f_dm_addr = 0; f_dm_wdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", ram_wdata, 32'd0);
    check("rst_if_ready", 32'(if_ready), 32'd0);
    check("rst_dm_ready", 32'(dm_ready), 32'd0);
    check("rst_dm_misalign", 32'(dm_mis), 32'd0);
    check("rst_rdata", if_rdata | dm_rdata, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; rst_n4 = 1'b1;
    mon_on = 1'b1;

    // Fetch of a known word
    do_dm(1'b1, 2'b11, 1'b0, 32'h10, 32'hDEAD_BEEF, dt0, dtr);
    check("sw_latency", 32'(dtr - dt0), 32'd2);
    do_if(32'h10, it0, itr);
    check("if_ram_en_cycle", 32'(last_en_cyc - it0), 32'd1);
    check("if_ram_addr", 32'(last_addr), 32'd4);
    check("if_ram_we", 32'(last_we), 32'd0);
    check("if_latency", 32'(itr - it0), 32'(2 + LAT));

    // Byte and half stores
    do_dm(1'b1, 2'b00, 1'b0, 32'h103, 32'h0000_00A5, dt0, dtr);
    check("sb_we", 32'(last_we), 32'b1000);
    check("sb_wdata", last_wdata, 32'hA5A5_A5A5);
    check("sb_latency", 32'(dtr - dt0), 32'd2);
    do_dm(1'b1, 2'b01, 1'b0, 32'h102, 32'h0000_1234, dt0, dtr);
    check("sh_we", 32'(last_we), 32'b1100);
    check("sh_wdata", last_wdata, 32'h1234_1234);
    check("sh_addr", 32'(last_addr), 32'h40);

    // Loads with extension
    do_dm(1'b1, 2'b11, 1'b0, 32'h100, 32'h0080_0000, dt0, dtr);
    do_dm(1'b0, 2'b00, 1'b0, 32'h102, 32'h0, dt0, dtr);
    check("lb_latency", 32'(dtr - dt0), 32'(2 + LAT));
    do_dm(1'b0, 2'b00, 1'b1, 32'h102, 32'h0, dt0, dtr);
    do_dm(1'b1, 2'b11, 1'b0, 32'h100, 32'h8001_0000, dt0, dtr);
    do_dm(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, dt0, dtr);
    do_dm(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, dt0, dtr);

    // Simultaneous requests: data side wins, stall held until fetch completes
    stall_bad = 0;
    fork
      do_dm(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, dt0, dtr);
      do_if(32'h204, it0, itr);
      begin
        @(posedge clk); #1;
        for (int n = 0; n < 100; n++) begin
          @(negedge clk);
          if (if_ready) break;
          if (!stall) stall_bad++;
        end
      end
    join
    check("arb_same_start", 32'(it0), 32'(dt0));
    check("arb_dm_first", 32'(dtr < itr), 32'd1);
    check("stall_held", 32'(stall_bad), 32'd0);

    // Misaligned word load: no RAM access, quick response
    cnt0 = en_cnt;
    do_dm(1'b0, 2'b11, 1'b0, 32'h102, 32'h0, dt0, dtr);
    check("mis_no_ram_en", 32'(en_cnt), 32'(cnt0));
    check("mis_latency", 32'(dtr - dt0), 32'd2);
    cnt0 = en_cnt;
    do_dm(1'b1, 2'b01, 1'b0, 32'h101, 32'hFFFF_FFFF, dt0, dtr);
    check("mis_store_no_ram_en", 32'(en_cnt), 32'(cnt0));

    // Randomized traffic from both requesters
    fork
      for (int n = 0; n < 40; n++) begin
        logic        rwe;
        logic [31:0] ra;
        rwe = 1'($urandom);
        ra  = 32'($urandom_range(0, 1023));
        if (rwe) ra = ra & 32'h1FF;
        do_dm(rwe, 2'($urandom_range(0, 3)), 1'($urandom), ra, $urandom, dt0, dtr);
        repeat ($urandom_range(0, 2)) @(posedge clk);
      end
      for (int n = 0; n < 30; n++) begin
        int a0, a1;
        do_if(32'($urandom_range(512, 1023)), a0, a1);
        repeat ($urandom_range(0, 3)) @(posedge clk);
      end
    join
    repeat (4) @(posedge clk);
    check("dm_queue_drained", 32'(dm_q.size()), 32'd0);
    check("if_queue_drained", 32'(if_q.size()), 32'd0);
    for (int i = 0; i < 128; i++) check("ram_contents", ram1[i], rd_word(4*i));

    // MEM_LAT=4: clean fetch
    @(posedge clk); #1;
    f_if_req = 1'b1; f_if_addr = 32'h47;
    t0 = cyc; itr = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (f_if_ready) begin itr = cyc; break; end
    end
    check("lat4_latency", 32'(itr - t0), 32'(2 + LAT4));
    check("lat4_rdata", f_if_rdata, init_word(32'h47 >> 2));
    @(posedge clk); #1;
    f_if_req = 1'b0;

    // MEM_LAT=4: reset while waiting on the RAM
    @(posedge clk); #1;
    f_if_req = 1'b1; f_if_addr = 32'h88;
    repeat (3) @(posedge clk);
    #1;
    rst_n4 = 1'b0;
    #1;
    check("abort_if_ready", 32'(f_if_ready), 32'd0);
    check("abort_ram_en", 32'(f_ram_en), 32'd0);
    check("abort_ram_addr", 32'(f_ram_addr), 32'd0);
    check("abort_if_rdata", f_if_rdata, 32'd0);
    f_if_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n4 = 1'b1;
    pulses = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (f_if_ready || f_ram_en) pulses++;
    end
    check("abort_no_response", 32'(pulses), 32'd0);
    @(posedge clk); #1;
    f_if_req = 1'b1; f_if_addr = 32'h90;
    t0 = cyc; itr = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (f_if_ready) begin itr = cyc; break; end
    end
    check("after_abort_latency", 32'(itr - t0), 32'(2 + LAT4));
    check("after_abort_rdata", f_if_rdata, init_word(32'h90 >> 2));
    @(posedge clk); #1;
    f_if_req = 1'b0;

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
